ram_port_arb: RTL and testbench
===============================

Name: ram_port_arb

Overview:
- Two-requester arbiter sharing one single-port RAM (32 x 8 default) between independent masters, e.g. a writer and a reader engine.
- Each master issues single-beat commands with a req/gnt handshake. The arbiter drives registered RAM controls and routes read data back to the issuing master with a valid strobe.
- Arbitration is round-robin with a burst-fairness limit, so neither master can starve the other.

Parameters:
- ADDR_W, 5: RAM address width.
- DATA_W, 8: RAM data width.
- RD_LAT, 1: cycles from ram_rd_en being sampled by the RAM to ram_rd_data being valid. Legal range 1..4.
- MAX_BURST, 4: maximum consecutive beats granted to one master while the other is requesting. Legal range 1..16.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 command request
- m0_we  in  1  master 0 command type: 1 = write, 0 = read
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_gnt  out  1  master 0 beat accepted this cycle
- m0_rdata  out  DATA_W  master 0 read data
- m0_rvalid  out  1  master 0 read data valid
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: same as m0_* for master 1
- ram_wr_en  out  1  RAM write enable
- ram_rd_en  out  1  RAM read enable
- ram_addr  out  ADDR_W  RAM address
- ram_wr_data  out  DATA_W  RAM write data
- ram_rd_data  in  DATA_W  RAM read data

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0; state IDLE; last_owner = 1 (so m0 wins the first tie); burst_cnt = 0; read-tag pipeline cleared.
- Handshake:
  - mN_gnt is combinational from the req inputs and the registered state. It is never asserted without mN_req.
  - A beat transfers when req & gnt are both high. At most one gnt per cycle.
  - A master holds addr, we and wdata stable while req is high and gnt is low.
- RAM command:
  - The accepted beat is registered. In cycle T+1 after acceptance at T: ram_addr = addr, ram_wr_data = wdata, ram_wr_en = we, ram_rd_en = !we.
  - With no accept, ram_wr_en and ram_rd_en are 0. ram_addr and ram_wr_data hold their last values.
- Read return:
  - A tag pipeline of length 1+RD_LAT carries {valid, owner}.
  - mN_rvalid pulses for exactly one cycle at T+1+RD_LAT.
  - m0_rdata and m1_rdata are both ram_rd_data registered at that same point, held until the next rvalid.
  - Writes produce no rvalid.
  - Back-to-back reads yield back-to-back rvalids in issue order.
- States:
  - IDLE: no owner. Any req grants immediately. If both request, grant !last_owner. Go to OWN0 or OWN1; burst_cnt = 1.
  - OWNn (n = current owner, m = the other master):
    - n requesting, m not requesting: grant n; burst_cnt saturates at MAX_BURST.
    - Both requesting, burst_cnt < MAX_BURST: grant n; burst_cnt++.
    - Both requesting, burst_cnt == MAX_BURST: grant m; go to OWNm; burst_cnt = 1; last_owner = n.
    - n not requesting, m requesting: grant m in the same cycle (no bubble); go to OWNm; burst_cnt = 1.
    - Neither requesting: go to IDLE; last_owner = n.
- Throughput: 1 beat per cycle sustained. No bubble on owner switch.
- Simultaneous events: a read issue and a read return in the same cycle are independent. A switch cycle may coincide with an rvalid for the previous owner.
- Same-address write then read from different masters: ordering is strict grant order, so the read returns the new data. This relies on the RAM having read-after-write behaviour across cycles.
- Reset mid-operation: tags are flushed, so no rvalid is emitted for in-flight reads. RAM enables drop to 0 asynchronously.
- Widths: burst_cnt is clog2(MAX_BURST+1) bits. Address wrap is the master's concern; the arbiter does no address arithmetic.

Decomposition:
- Shared package ram_arb_pkg:
  - state encoding (IDLE, OWN0, OWN1)
  - OWNER_M0 = 0, OWNER_M1 = 1
  - default ADDR_W and DATA_W constants
- One sub-module, ram_rd_tag_pipe: parameterised delay line of {valid, owner} with depth 1+RD_LAT and async clear.
- Arbitration FSM and RAM command register stay in the top module.

Test Plan (ADDR_W=5, DATA_W=8, RD_LAT=1, MAX_BURST=4):
- Single master: m0 writes addr 0..31 with data 1..32, then reads 0..31 → ram_wr_en high 32 consecutive cycles; m0_rvalid in 32 consecutive cycles with data 1..32; m1_rvalid never asserted.
- Tie from IDLE after reset: m0_req and m1_req both rise at the same edge → m0_gnt first. Both then hold req → pattern is 4 m0 beats, 4 m1 beats, repeating, with no idle cycle.
- Owner drops: m1 owns after 2 beats, m1_req falls while m0_req is high → m0_gnt in the same cycle; burst_cnt restarts at 1.
- Interleaved reads: m0 reads addr 3 (data 0x04) and m1 reads addr 7 (data 0x08) on consecutive cycles → m0_rvalid with 0x04, then m1_rvalid with 0x08 on the next cycle; each rvalid is exactly one cycle wide.
- Reset mid-burst: deassert rst_n one cycle after a read is accepted → no rvalid afterwards; all outputs 0. After release, first tie goes to m0.
- Cross-master coherence: m1 writes 0xA5 to addr 10, and m0's read of addr 10 is granted the next cycle → m0_rdata = 0xA5.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_rd_tag_pipe.sv
// Delay line of {valid, owner} tags that follows each read through the RAM.
module ram_rd_tag_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_owner,
  output logic out_valid,
  output logic out_owner
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] own_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      own_q[0] <= in_owner;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_owner = own_q[DEPTH-1];

endmodule

// File: rtl/ram_port_arb.sv
// Round-robin arbiter with burst-fairness limit sharing one single-port RAM between two masters.
module ram_port_arb
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  arb_state_e          state_q, state_d;
  logic                last_q, last_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic                grant, grant_sel;
  logic                cur, cur_req, oth_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= OWNER_M1;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    burst_d   = burst_q;
    grant     = 1'b0;
    grant_sel = OWNER_M0;
    cur       = (state_q == OWN1) ? OWNER_M1 : OWNER_M0;
    cur_req   = cur ? m1_req : m0_req;
    oth_req   = cur ? m0_req : m1_req;
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant     = 1'b1;
          grant_sel = (m0_req && m1_req) ? ~last_q : m1_req;
          state_d   = grant_sel ? OWN1 : OWN0;
          burst_d   = BURST_ONE;
        end
      end
      OWN0, OWN1: begin
        // Owner keeps the port unless contested at the burst limit; lone owner saturates.
        if (cur_req && (!oth_req || burst_q != BURST_MAX)) begin
          grant     = 1'b1;
          grant_sel = cur;
          if (burst_q != BURST_MAX) burst_d = burst_q + BURST_ONE;
        end else if (oth_req) begin
          grant     = 1'b1;
          grant_sel = ~cur;
          state_d   = cur ? OWN0 : OWN1;
          burst_d   = BURST_ONE;
          if (cur_req) last_d = cur;
        end else begin
          state_d = IDLE;
          last_d  = cur;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_gnt = grant & (grant_sel == OWNER_M0);
  assign m1_gnt = grant & (grant_sel == OWNER_M1);

  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  assign acc_we    = grant_sel ? m1_we    : m0_we;
  assign acc_addr  = grant_sel ? m1_addr  : m0_addr;
  assign acc_wdata = grant_sel ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr_en   <= 1'b0;
      ram_rd_en   <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
    end else begin
      ram_wr_en <= grant & acc_we;
      ram_rd_en <= grant & ~acc_we;
      if (grant) begin
        ram_addr    <= acc_addr;
        ram_wr_data <= acc_wdata;
      end
    end
  end

  logic tag_valid, tag_owner;

  ram_rd_tag_pipe #(
    .DEPTH (1 + RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (grant & ~acc_we),
    .in_owner  (grant_sel),
    .out_valid (tag_valid),
    .out_owner (tag_owner)
  );

  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rdata_q <= '0;
    else if (tag_valid) rdata_q <= ram_rd_data;
  end

  // Return data is live during the rvalid cycle and held from the register afterwards.
  assign rdata_out = tag_valid ? ram_rd_data : rdata_q;
  assign m0_rdata  = rdata_out;
  assign m1_rdata  = rdata_out;
  assign m0_rvalid = tag_valid & (tag_owner == OWNER_M0);
  assign m1_rvalid = tag_valid & (tag_owner == OWNER_M1);

endmodule

// File: tb/tb_ram_port_arb.sv
// Self-checking bench for ram_port_arb: directed scenarios plus random traffic against a reference model.
module tb_ram_port_arb;

  localparam int RD_LAT = 1;
  localparam int MAXB   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [4:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [7:0] m0_rdata, m1_rdata;
  logic       ram_wr_en, ram_rd_en;
  logic [4:0] ram_addr;
  logic [7:0] ram_wr_data, ram_rd_data;

  always #5 clk = ~clk;

  ram_port_arb #(
    .ADDR_W    (5),
    .DATA_W    (8),
    .RD_LAT    (RD_LAT),
    .MAX_BURST (MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
  );

  // Synchronous single-port RAM fixture, one cycle read latency.
  logic [7:0] mem [32];
  logic [7:0] rd_q;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
    if (ram_rd_en) rd_q <= mem[ram_addr];
  end
  assign ram_rd_data = rd_q;

  // Reference model state
  typedef struct { int owner; logic [7:0] data; int due; } ret_t;
  ret_t       rq[$];
  logic [7:0] shadow [32];
  int         own, run, last, cyc, last_w;
  logic       exp_we, exp_re;
  logic [4:0] exp_addr;
  logic [7:0] exp_wd, held;

  int n_checks = 0, n_fail = 0;
  int cnt_wr, cnt_rv0, cnt_rv1;
  logic       obs_g0, obs_g1, obs_rv0, obs_rv1;
  logic [7:0] obs_rd0;
  int         win [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    own = -1; run = 0; last = 1;
    exp_we = 0; exp_re = 0; exp_addr = '0; exp_wd = '0; held = '0;
  endtask

  task automatic tick();
    int w, n;
    logic r0, r1, rn, rm, ev0, ev1, we;
    logic [4:0] a;
    logic [7:0] d;
    @(negedge clk);
    r0 = m0_req; r1 = m1_req; w = -1;
    if (own < 0) begin
      if (r0 && r1) w = 1 - last;
      else if (r0)  w = 0;
      else if (r1)  w = 1;
      if (w >= 0) begin own = w; run = 1; end
    end else begin
      n  = own;
      rn = (n == 1) ? r1 : r0;
      rm = (n == 1) ? r0 : r1;
      if (rn && !rm)                  begin w = n; if (run < MAXB) run++; end
      else if (rn && rm && run < MAXB) begin w = n; run++; end
      else if (rn && rm)              begin w = 1 - n; own = w; run = 1; last = n; end
      else if (rm)                    begin w = 1 - n; own = w; run = 1; end
      else                            begin own = -1; last = n; end
    end
    ev0 = 0; ev1 = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].owner == 0) ev0 = 1; else ev1 = 1;
      held = rq[0].data;
      void'(rq.pop_front());
    end
    chk("m0_gnt", 32'(m0_gnt), 32'(w == 0));
    chk("m1_gnt", 32'(m1_gnt), 32'(w == 1));
    chk("ram_wr_en", 32'(ram_wr_en), 32'(exp_we));
    chk("ram_rd_en", 32'(ram_rd_en), 32'(exp_re));
    chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
    chk("ram_wr_data", 32'(ram_wr_data), 32'(exp_wd));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(ev0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(ev1));
    chk("m0_rdata", 32'(m0_rdata), 32'(held));
    chk("m1_rdata", 32'(m1_rdata), 32'(held));
    obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid; obs_rd0 = m0_rdata;
    if (ram_wr_en) cnt_wr++;
    if (m0_rvalid) cnt_rv0++;
    if (m1_rvalid) cnt_rv1++;
    exp_we = 0; exp_re = 0;
    if (w >= 0) begin
      we = (w == 1) ? m1_we : m0_we;
      a  = (w == 1) ? m1_addr : m0_addr;
      d  = (w == 1) ? m1_wdata : m0_wdata;
      exp_we = we; exp_re = !we; exp_addr = a; exp_wd = d;
      if (we) shadow[a] = d;
      else    rq.push_back('{w, shadow[a], cyc + 1 + RD_LAT});
    end
    last_w = w;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [4:0] a, input logic [7:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [4:0] a, input logic [7:0] d);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  task automatic do_reset();
    set_m0(0, 0, '0, '0); set_m1(0, 0, '0, '0);
    rst_n = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic rand_drive();
    if (!(m0_req && last_w != 0))
      set_m0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom));
    if (!(m1_req && last_w != 1))
      set_m1($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom));
  endtask

  initial begin
    int pre;
    cyc = 0; last_w = -1;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    set_m0(0, 0, '0, '0); set_m1(0, 0, '0, '0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    tick();

    // Single master: 32 writes then 32 reads
    cnt_wr = 0; cnt_rv0 = 0; cnt_rv1 = 0;
    for (int i = 0; i < 32; i++) begin set_m0(1, 1, 5'(i), 8'(i + 1)); tick(); end
    for (int i = 0; i < 32; i++) begin set_m0(1, 0, 5'(i), 8'h00); tick(); end
    set_m0(0, 0, '0, '0);
    repeat (4) tick();
    chk("single_wr_count", 32'(cnt_wr), 32);
    chk("single_rv0_count", 32'(cnt_rv0), 32);
    chk("single_rv1_count", 32'(cnt_rv1), 0);

    // Tie from IDLE after reset: 4 m0 beats, 4 m1 beats, repeating
    do_reset();
    tick();
    set_m0(1, 0, 5'd2, '0); set_m1(1, 0, 5'd9, '0);
    for (int i = 0; i < 16; i++) begin
      tick();
      win[i] = obs_g0 ? 0 : (obs_g1 ? 1 : 2);
    end
    for (int i = 0; i < 16; i++) chk($sformatf("tie_seq[%0d]", i), 32'(win[i]), 32'((i / 4) % 2));
    set_m0(0, 0, '0, '0); set_m1(0, 0, '0, '0);
    repeat (3) tick();

    // Owner drops after 2 beats: no bubble, burst restarts at 1
    set_m1(1, 0, 5'd1, '0);
    tick(); tick();
    set_m1(0, 0, '0, '0); set_m0(1, 0, 5'd4, '0);
    tick();
    chk("drop_switch_gnt0", 32'(obs_g0), 1);
    set_m1(1, 0, 5'd6, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      win[i] = obs_g0 ? 0 : (obs_g1 ? 1 : 2);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("drop_burst[%0d]", i), 32'(win[i]), (i < 3) ? 0 : 1);
    set_m0(0, 0, '0, '0); set_m1(0, 0, '0, '0);
    repeat (3) tick();

    // Interleaved reads from both masters
    set_m0(1, 0, 5'd3, '0); tick();
    set_m0(0, 0, '0, '0); set_m1(1, 0, 5'd7, '0); tick();
    set_m1(0, 0, '0, '0); tick();
    chk("ilv_rv0", 32'(obs_rv0), 1);
    chk("ilv_rd0", 32'(obs_rd0), 32'h04);
    tick();
    chk("ilv_rv1", 32'(obs_rv1), 1);
    chk("ilv_rv0_width", 32'(obs_rv0), 0);
    chk("ilv_rd1", 32'(m1_rdata), 32'h08);
    repeat (2) tick();

    // Reset one cycle after a read is accepted
    set_m0(1, 0, 5'd5, '0); tick();
    pre = cnt_rv0 + cnt_rv1;
    do_reset();
    repeat (3) tick();
    chk("reset_no_rvalid", 32'(cnt_rv0 + cnt_rv1 - pre), 0);
    set_m0(1, 0, 5'd0, '0); set_m1(1, 0, 5'd1, '0);
    tick();
    chk("reset_tie_m0", 32'(obs_g0), 1);
    set_m0(0, 0, '0, '0); set_m1(0, 0, '0, '0);
    repeat (4) tick();

    // Cross-master coherence: m1 writes, m0 reads the same address next cycle
    set_m1(1, 1, 5'd10, 8'hA5); tick();
    set_m1(0, 0, '0, '0); set_m0(1, 0, 5'd10, '0); tick();
    set_m0(0, 0, '0, '0); tick(); tick();
    chk("coh_rv0", 32'(obs_rv0), 1);
    chk("coh_rdata", 32'(obs_rd0), 32'hA5);
    tick();

    // Random traffic honouring the hold-while-waiting rule
    for (int i = 0; i < 400; i++) begin rand_drive(); tick(); end
    set_m0(0, 0, '0, '0); set_m1(0, 0, '0, '0);
    repeat (5) tick();
    chk("drain_queue", 32'(rq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
